// File: rtl/pipe_hold_ctrl_pkg.sv
// rtl/pipe_hold_ctrl_pkg.sv - shared hold-flag codes, bus layout and FSM states
package pipe_hold_ctrl_pkg;

  // Per-boundary pipeline register command
  typedef logic [2:0] hold_flag_t;

  localparam hold_flag_t HOLD_RUN   = 3'b000;
  localparam hold_flag_t HOLD_FLUSH = 3'b001;
  localparam hold_flag_t HOLD_STALL = 3'b010;

  // The four boundaries in pipeline order, fetch side first
  typedef struct packed {
    hold_flag_t if_id;
    hold_flag_t id_ex;
    hold_flag_t ex_mem;
    hold_flag_t mem_wb;
  } hold_bus_t;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  // Build a bus with the same command on every boundary
  function automatic hold_bus_t all_flags(input hold_flag_t f);
    hold_bus_t b;
    b.if_id  = f;
    b.id_ex  = f;
    b.ex_mem = f;
    b.mem_wb = f;
    return b;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_stall_watchdog.sv
// rtl/pipe_hold_ctrl_stall_watchdog.sv - consecutive-stall run-length counter with sticky timeout flag
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall,
  output logic o_timeout
);

  localparam int RW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RW-1:0] LIMIT = RW'(STALL_TIMEOUT);

  logic [RW-1:0] r_run;
  logic          r_timeout;

  // Run length saturates at the limit so it can never wrap back below it;
  // the flag is set on the same edge the run length reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else if (i_stall) begin
      if (r_run != LIMIT) begin
        r_run <= r_run + 1'b1;
      end
      if (r_run >= LIMIT - 1'b1) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_run <= '0;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// rtl/pipe_hold_ctrl.sv - pipeline hold/flush arbiter with trap sequencing, jump deferral and stall statistics
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 2,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             ex_stall_req,
  input  logic             mem_stall_req,
  input  logic             jump_req,
  input  logic             trap_req,
  output logic             trap_ack,
  output logic             jump_commit,
  output logic             pc_hold,
  output logic [2:0]       hold_if_id,
  output logic [2:0]       hold_id_ex,
  output logic [2:0]       hold_ex_mem,
  output logic [2:0]       hold_mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FW-1:0]    r_flush_cnt;
  logic [FW-1:0]    w_flush_cnt_nxt;
  logic             r_jump_pend;
  logic             w_jump_pend_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;
  logic             w_trap;
  hold_bus_t        w_bus;

  // State, flush counter and deferred-jump flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RESET;
      r_flush_cnt <= '0;
      r_jump_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_jump_pend <= w_jump_pend_nxt;
    end
  end

  // Next state and flag decode; a trap seen in S_RUN already counts as the
  // first flush cycle, so exactly FLUSH_CYCLES cycles are flushed per trap.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = '0;
    w_jump_pend_nxt = r_jump_pend;
    w_bus           = all_flags(HOLD_FLUSH);
    pc_hold         = 1'b1;
    trap_ack        = 1'b0;
    jump_commit     = 1'b0;
    w_stall         = 1'b0;
    w_trap          = 1'b0;

    case (r_state)
      S_RESET: begin
        w_state_nxt     = S_RUN;
        w_jump_pend_nxt = 1'b0;
      end
      S_TRAP: begin
        w_trap = 1'b1;
      end
      S_RUN: begin
        if (trap_req) begin
          w_trap = 1'b1;
        end else if (mem_stall_req) begin
          w_bus.if_id  = HOLD_STALL;
          w_bus.id_ex  = HOLD_STALL;
          w_bus.ex_mem = HOLD_STALL;
          w_bus.mem_wb = HOLD_FLUSH;
          w_stall      = 1'b1;
          if (jump_req) w_jump_pend_nxt = 1'b1;
        end else if (ex_stall_req) begin
          w_bus.if_id  = HOLD_STALL;
          w_bus.id_ex  = HOLD_STALL;
          w_bus.ex_mem = HOLD_FLUSH;
          w_bus.mem_wb = HOLD_RUN;
          w_stall      = 1'b1;
          if (jump_req) w_jump_pend_nxt = 1'b1;
        end else if (jump_req || r_jump_pend) begin
          w_bus.if_id     = HOLD_FLUSH;
          w_bus.id_ex     = HOLD_FLUSH;
          w_bus.ex_mem    = HOLD_RUN;
          w_bus.mem_wb    = HOLD_RUN;
          pc_hold         = 1'b0;
          jump_commit     = 1'b1;
          w_jump_pend_nxt = 1'b0;
        end else if (if_stall_req) begin
          w_bus        = all_flags(HOLD_RUN);
          w_bus.if_id  = HOLD_FLUSH;
          w_stall      = 1'b1;
        end else begin
          w_bus   = all_flags(HOLD_RUN);
          pc_hold = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase

    if (w_trap) begin
      w_bus           = all_flags(HOLD_FLUSH);
      pc_hold         = 1'b0;
      w_jump_pend_nxt = 1'b0;
      if (r_flush_cnt == FLUSH_LAST) begin
        trap_ack        = 1'b1;
        w_state_nxt     = S_RUN;
        w_flush_cnt_nxt = '0;
      end else begin
        w_state_nxt     = S_TRAP;
        w_flush_cnt_nxt = r_flush_cnt + 1'b1;
      end
    end
  end

  // Saturating count of all stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (w_stall),
    .o_timeout (stall_timeout)
  );

  assign hold_if_id  = w_bus.if_id;
  assign hold_id_ex  = w_bus.id_ex;
  assign hold_ex_mem = w_bus.ex_mem;
  assign hold_mem_wb = w_bus.mem_wb;
  assign stall_cnt   = r_stall_cnt;

endmodule
